// File: rtl/ram_arbiter_pkg.sv
// Shared types and helpers for the RAM arbiter.
// Optional feature macro: RAM_ARB_RR_EN (round-robin IDLE arbitration).
package ram_arbiter_pkg;

    // Arbiter FSM state, kept as plain constants for older tool flows
    typedef logic [0:0] arb_state_t;
    localparam arb_state_t ARB_IDLE   = 1'b0;
    localparam arb_state_t ARB_LOCKED = 1'b1;

    // Width needed to count 0..n-1 (never below one bit)
    function automatic int lock_cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ram_arbiter_if.sv
// Requester-side bus of the RAM arbiter: request handshake and read response.
interface ram_arbiter_if #(
    parameter int NREQ  = 3,
    parameter int AW    = 13,
    parameter int WIDTH = 8
);
    import ram_arbiter_pkg::*;

    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ-1:0]       req_write;
    logic [NREQ-1:0]       req_lock;
    logic [NREQ*AW-1:0]    req_addr;
    logic [NREQ*WIDTH-1:0] req_wdata;
    logic [NREQ-1:0]       rsp_valid;
    logic [WIDTH-1:0]      rsp_data;

    // Requesters side
    modport master (
        output req_valid, req_write, req_lock, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_data
    );

    // Arbiter side
    modport slave (
        input  req_valid, req_write, req_lock, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_data
    );
endinterface

// File: rtl/ram_arb_pick.sv
// Combinational one-hot picker: first valid bit found searching upward from
// 'start' with wrap-around. start=0 gives plain fixed priority.
module ram_arb_pick
    import ram_arbiter_pkg::*;
#(
    parameter  int N  = 3,
    localparam int IW = lock_cnt_w(N)
) (
    input  logic [N-1:0]  valid,
    input  logic [IW-1:0] start,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] gnt_idx
);

    int   idx;
    logic found;

    // Rotating priority scan; the first hit wins and masks the rest
    always_comb begin
        grant   = '0;
        gnt_idx = '0;
        found   = 1'b0;
        idx     = 0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(start) + k) % N;
            if (!found && valid[idx]) begin
                grant[idx] = 1'b1;
                gnt_idx    = IW'(idx);
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ram_arbiter.sv
// Single-port synchronous RAM arbiter with bus lock and lock timeout.
// Optional feature macro: RAM_ARB_RR_EN -- when defined, IDLE grants rotate
// round-robin; otherwise requester 0 has fixed highest priority.
module ram_arbiter
    import ram_arbiter_pkg::*;
#(
    parameter  int NREQ     = 3,
    parameter  int WORDS    = 8192,
    parameter  int WIDTH    = 8,
    parameter  int LOCK_MAX = 160,
    localparam int AW       = $clog2(WORDS)
) (
    input  logic             clk,
    input  logic             reset,
    ram_arbiter_if.slave     bus,
    output logic [AW-1:0]    ram_addr,
    output logic             ram_write,
    output logic [WIDTH-1:0] ram_d_in,
    input  logic [WIDTH-1:0] ram_d_out
);

    localparam int IW = lock_cnt_w(NREQ);
    localparam int CW = lock_cnt_w(LOCK_MAX);

    arb_state_t      state_q;
    logic [IW-1:0]   owner_q;
    logic [CW-1:0]   lock_cnt_q;
    logic [NREQ-1:0] rsp_vld_q;

    logic [NREQ-1:0] cand;
    logic [NREQ-1:0] grant;
    logic [IW-1:0]   win;
    logic [IW-1:0]   start;
    logic            xfer;
    logic            win_wr;
    logic            win_lock;
    logic            lock_expire;

    // Candidate set: nobody in reset, only the owner while locked
    always_comb begin
        cand = '0;
        if (!reset) begin
            if (state_q == ARB_LOCKED)
                cand[owner_q] = bus.req_valid[owner_q];
            else
                cand = bus.req_valid;
        end
    end

`ifdef RAM_ARB_RR_EN
    logic [IW-1:0] rr_ptr_q;

    // Rotate past the last IDLE winner; locked grants leave the pointer alone
    always_ff @(posedge clk) begin
        if (reset)
            rr_ptr_q <= '0;
        else if (state_q == ARB_IDLE && xfer)
            rr_ptr_q <= (int'(win) == NREQ - 1) ? '0 : win + IW'(1);
    end

    assign start = rr_ptr_q;
`else
    assign start = '0;
`endif

    ram_arb_pick #(.N(NREQ)) u_pick (
        .valid   (cand),
        .start   (start),
        .grant   (grant),
        .gnt_idx (win)
    );

    assign bus.req_ready = grant;
    assign xfer          = |grant;
    assign win_wr        = bus.req_write[win];
    assign win_lock      = bus.req_lock[win];
    assign lock_expire   = (lock_cnt_q == CW'(LOCK_MAX - 1));

    // With no grant win is 0, so the RAM sees requester 0's fields (don't-care)
    assign ram_addr  = bus.req_addr[int'(win)*AW +: AW];
    assign ram_d_in  = bus.req_wdata[int'(win)*WIDTH +: WIDTH];
    assign ram_write = xfer & win_wr;

    // Remember who issued a read; the RAM returns it one cycle later
    always_ff @(posedge clk) begin
        if (reset)
            rsp_vld_q <= '0;
        else
            rsp_vld_q <= grant & ~bus.req_write;
    end

    // Masking with reset drops a response for a read accepted just before reset
    assign bus.rsp_valid = rsp_vld_q & {NREQ{~reset}};
    assign bus.rsp_data  = ram_d_out;

    // Lock FSM: enter on a locked transfer, leave on unlock or timeout
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ARB_IDLE;
            owner_q    <= '0;
            lock_cnt_q <= '0;
        end else begin
            case (state_q)
                ARB_IDLE: begin
                    if (xfer && win_lock) begin
                        state_q    <= ARB_LOCKED;
                        owner_q    <= win;
                        lock_cnt_q <= '0;
                    end
                end
                ARB_LOCKED: begin
                    if ((xfer && !win_lock) || lock_expire) begin
                        state_q    <= ARB_IDLE;
                        lock_cnt_q <= '0;
                    end else begin
                        lock_cnt_q <= lock_cnt_q + CW'(1);
                    end
                end
                default: begin
                    state_q    <= ARB_IDLE;
                    lock_cnt_q <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed self-checking bench for ram_arbiter (default and short-timeout builds).
module tb_ram_arbiter;

    localparam int NREQ  = 3;
    localparam int AW    = 13;
    localparam int WIDTH = 8;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    int errs   = 0;
    int checks = 0;

    // Main DUT (LOCK_MAX=160)
    ram_arbiter_if #(.NREQ(NREQ), .AW(AW), .WIDTH(WIDTH)) bus ();
    logic [AW-1:0]    ram_addr;
    logic             ram_write;
    logic [WIDTH-1:0] ram_d_in;
    logic [WIDTH-1:0] ram_d_out;

    ram_arbiter dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .ram_addr  (ram_addr),
        .ram_write (ram_write),
        .ram_d_in  (ram_d_in),
        .ram_d_out (ram_d_out)
    );

    // Short-timeout DUT (LOCK_MAX=4) mirrors the main request inputs
    ram_arbiter_if #(.NREQ(NREQ), .AW(AW), .WIDTH(WIDTH)) bus4 ();
    logic [AW-1:0]    ram4_addr;
    logic             ram4_write;
    logic [WIDTH-1:0] ram4_d_in;
    logic [WIDTH-1:0] ram4_d_out;

    assign bus4.req_valid = bus.req_valid;
    assign bus4.req_write = bus.req_write;
    assign bus4.req_lock  = bus.req_lock;
    assign bus4.req_addr  = bus.req_addr;
    assign bus4.req_wdata = bus.req_wdata;
    assign ram4_d_out     = '0;

    ram_arbiter #(.LOCK_MAX(4)) dut4 (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus4),
        .ram_addr  (ram4_addr),
        .ram_write (ram4_write),
        .ram_d_in  (ram4_d_in),
        .ram_d_out (ram4_d_out)
    );

    // Behavioural single-port RAM with registered read
    logic [WIDTH-1:0] mem [0:8191];
    always @(posedge clk) begin
        if (ram_write) mem[ram_addr] <= ram_d_in;
        ram_d_out <= mem[ram_addr];
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        bus.req_valid = '0;
        bus.req_write = '0;
        bus.req_lock  = '0;
    endtask

    task automatic set_req(input int i, input logic wr, input logic lk,
                           input logic [AW-1:0] a, input logic [WIDTH-1:0] d);
        bus.req_valid[i]             = 1'b1;
        bus.req_write[i]             = wr;
        bus.req_lock[i]              = lk;
        bus.req_addr[i*AW +: AW]     = a;
        bus.req_wdata[i*WIDTH +: WIDTH] = d;
    endtask

    logic [AW-1:0]    a;
    logic [WIDTH-1:0] d;

    initial begin
        for (int i = 0; i < 8192; i++) mem[i] = '0;
        mem[13'h0123] = 8'h5A;
        mem[13'h0010] = 8'h11;
        mem[13'h0020] = 8'h22;

        reset = 1'b1;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        clr();

        // Reset: everything requests writes, nothing may be granted
        repeat (2) @(posedge clk);
        #1;
        bus.req_valid = 3'b111;
        bus.req_write = 3'b111;
        @(negedge clk);
        chk("rst_ready", 32'(bus.req_ready), 32'h0);
        chk("rst_ramwr", 32'(ram_write), 32'h0);
        chk("rst_rspv", 32'(bus.rsp_valid), 32'h0);
        nxt();
        reset = 1'b0;
        clr();

        // Single read by requester 1
        set_req(1, 1'b0, 1'b0, 13'h0123, 8'h00);
        @(negedge clk);
        chk("rd_ready", 32'(bus.req_ready), 32'b010);
        chk("rd_addr", 32'(ram_addr), 32'h0123);
        chk("rd_ramwr", 32'(ram_write), 32'h0);
        nxt();
        clr();
        @(negedge clk);
        chk("rd_rspv", 32'(bus.rsp_valid), 32'b010);
        chk("rd_data", 32'(bus.rsp_data), 32'h5A);

        // Contention between requesters 0 and 2
        nxt();
        set_req(0, 1'b0, 1'b0, 13'h0010, 8'h00);
        set_req(2, 1'b0, 1'b0, 13'h0020, 8'h00);
`ifdef RAM_ARB_RR_EN
        // rr_ptr is 2 after the read by requester 1
        @(negedge clk);
        chk("rr_g0", 32'(bus.req_ready), 32'b100);
        nxt();
        @(negedge clk);
        chk("rr_g1", 32'(bus.req_ready), 32'b001);
        chk("rr_rsp1", 32'(bus.rsp_valid), 32'b100);
        chk("rr_dat1", 32'(bus.rsp_data), 32'h22);
        nxt();
        @(negedge clk);
        chk("rr_g2", 32'(bus.req_ready), 32'b100);
        nxt();
        @(negedge clk);
        chk("rr_g3", 32'(bus.req_ready), 32'b001);
        nxt();
        clr();
        @(negedge clk);
        chk("rr_rsp3", 32'(bus.rsp_valid), 32'b001);
        chk("rr_dat3", 32'(bus.rsp_data), 32'h11);
`else
        @(negedge clk);
        chk("fp_g0", 32'(bus.req_ready), 32'b001);
        nxt();
        bus.req_valid[0] = 1'b0;
        @(negedge clk);
        chk("fp_g1", 32'(bus.req_ready), 32'b100);
        chk("fp_rsp0", 32'(bus.rsp_valid), 32'b001);
        chk("fp_dat0", 32'(bus.rsp_data), 32'h11);
        nxt();
        clr();
        @(negedge clk);
        chk("fp_rsp2", 32'(bus.rsp_valid), 32'b100);
        chk("fp_dat2", 32'(bus.rsp_data), 32'h22);
`endif

        // Write then read the top address
        nxt();
        set_req(0, 1'b1, 1'b0, 13'h1FFF, 8'h77);
        @(negedge clk);
        chk("wr_ready", 32'(bus.req_ready), 32'b001);
        chk("wr_ramwr", 32'(ram_write), 32'h1);
        chk("wr_addr", 32'(ram_addr), 32'h1FFF);
        chk("wr_din", 32'(ram_d_in), 32'h77);
        nxt();
        set_req(0, 1'b0, 1'b0, 13'h1FFF, 8'h00);
        @(negedge clk);
        chk("wr_rd_ramwr", 32'(ram_write), 32'h0);
        chk("wr_no_rsp", 32'(bus.rsp_valid), 32'h0);
        nxt();
        clr();
        @(negedge clk);
        chk("wr_rd_rspv", 32'(bus.rsp_valid), 32'b001);
        chk("wr_rd_data", 32'(bus.rsp_data), 32'h77);

        // Locked burst of 10 writes by requester 2, requester 0 waiting
        nxt();
        set_req(2, 1'b1, 1'b1, 13'h0100, 8'hA0);
        @(negedge clk);
        chk("bl_g0", 32'(bus.req_ready), 32'b100);
        for (int k = 1; k < 10; k++) begin
            nxt();
            a = 13'h0100 + AW'(k);
            d = 8'hA0 + WIDTH'(k);
            set_req(2, 1'b1, (k != 9), a, d);
            set_req(0, 1'b0, 1'b0, 13'h0010, 8'h00);
            @(negedge clk);
            chk($sformatf("bl_g%0d", k), 32'(bus.req_ready), 32'b100);
        end
        nxt();
        bus.req_valid[2] = 1'b0;
        @(negedge clk);
        chk("bl_rel", 32'(bus.req_ready), 32'b001);
        nxt();
        clr();
        @(negedge clk);
        chk("bl_rspv", 32'(bus.rsp_valid), 32'b001);
        chk("bl_data", 32'(bus.rsp_data), 32'h11);
        chk("bl_mem0", 32'(mem[13'h0100]), 32'hA0);
        chk("bl_mem9", 32'(mem[13'h0109]), 32'hA9);

        // Lock timeout on the LOCK_MAX=4 instance
        repeat (8) nxt();
        set_req(2, 1'b0, 1'b1, 13'h0020, 8'h00);
        @(negedge clk);
        chk("to_lock", 32'(bus4.req_ready), 32'b100);
        nxt();
        clr();
        set_req(0, 1'b0, 1'b0, 13'h0010, 8'h00);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk($sformatf("to_hold%0d", k), 32'(bus4.req_ready), 32'h0);
            nxt();
        end
        @(negedge clk);
        chk("to_grant", 32'(bus4.req_ready), 32'b001);
        chk("to_main_held", 32'(bus.req_ready), 32'h0);
        nxt();
        clr();

        // Reset right after an accepted locked read
        set_req(2, 1'b0, 1'b1, 13'h0020, 8'h00);
        @(negedge clk);
        chk("rr_acc", 32'(bus.req_ready), 32'b100);
        nxt();
        clr();
        reset = 1'b1;
        @(negedge clk);
        chk("rm_rspv", 32'(bus.rsp_valid), 32'h0);
        chk("rm_ready", 32'(bus.req_ready), 32'h0);
        nxt();
        reset = 1'b0;
        set_req(0, 1'b0, 1'b0, 13'h0123, 8'h00);
        @(negedge clk);
        chk("rm_post_g", 32'(bus.req_ready), 32'b001);
        chk("rm_post_rspv", 32'(bus.rsp_valid), 32'h0);
        nxt();
        clr();
        @(negedge clk);
        chk("rm_post_rsp", 32'(bus.rsp_valid), 32'b001);
        chk("rm_post_dat", 32'(bus.rsp_data), 32'h5A);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
